// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults, FSM encoding and baud-tick divider formula
package uart_pkg;
  localparam int CLK_HZ = 100_000_000;
  localparam int OVS_DEF = 8;
  localparam int DATA_BITS_DEF = 8;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  function automatic int tick_div(input int baud, input int ovs);
    return CLK_HZ / (baud * ovs);
  endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchronizer for an asynchronous input, reset to RST_VAL
module bit_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= {RST_VAL, RST_VAL};
    else     {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver on an OVS-times oversampled tick, one-cycle done/error strobes
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS       = OVS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  logic                 rx_s;
  logic [1:0]           state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n, rx_data_n;
  logic                 done_n, err_n;
  bit_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign rx_busy = state != IDLE;
  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    shift_n   = shift;
    rx_data_n = rx_data;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        tick_n  = '0;
        state_n = START;
      end
      START: if (b_tick) begin
        tick_n = tick_cnt + 1'b1;
        if (tick_cnt == T_HALF) begin
          tick_n  = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: if (b_tick) begin
        tick_n = (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == T_LAST) begin
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          bit_n   = bit_cnt + 1'b1;
          state_n = (bit_cnt == B_LAST) ? STOP : DATA;
        end
      end
      default: if (b_tick) begin
        tick_n = tick_cnt + 1'b1;
        // leave at mid-stop-bit so an immediately following start edge is caught
        if (tick_cnt == T_LAST) begin
          tick_n    = '0;
          state_n   = IDLE;
          done_n    = rx_s;
          err_n     = !rx_s;
          rx_data_n = rx_s ? shift : rx_data;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      rx_data   <= rx_data_n;
      rx_done   <= done_n;
      frame_err <= err_n;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames on a shortened tick period with hand-computed expectations
module tb_uart_rx;
  localparam int DIV = 16;
  localparam int OVS = 8;
  localparam int BIT = DIV * OVS;
  logic       clk = 1'b0;
  logic       rst;
  logic       b_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err;
  int vecs = 0, errs = 0;
  int n_done = 0, n_err = 0, n_both = 0, n_busy_done = 0, n_busy = 0;
  int d, e, b, qs;
  logic [7:0] got_q[$];
  uart_rx #(.OVS(OVS), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (DIV - 1) @(negedge clk);
    b_tick = 1'b1;
    @(negedge clk);
    b_tick = 1'b0;
  end
  always @(negedge clk) begin
    if (rx_done) begin
      n_done++;
      got_q.push_back(rx_data);
      if (rx_busy) n_busy_done++;
    end
    if (frame_err) n_err++;
    if (rx_done && frame_err) n_both++;
    if (rx_busy) n_busy++;
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task send(input logic [7:0] v, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    for (int i = 0; i < BIT; i++) begin
      @(negedge clk);
      if (frame_err) rx = 1'b1;
    end
    rx = 1'b1;
  endtask
  initial begin
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_done", rx_done, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", frame_err, 0);
    b = n_busy;
    repeat (2000) @(negedge clk);
    check("idle_busy", n_busy - b, 0);
    d = n_done; e = n_err;
    send(8'h55, 1'b1);
    repeat (BIT) @(negedge clk);
    check("f55_cnt", n_done - d, 1);
    check("f55_q", got_q[got_q.size() - 1], 8'h55);
    check("f55_data", rx_data, 8'h55);
    check("f55_ferr", n_err - e, 0);
    check("f55_busy_at_done", n_busy_done, 0);
    d = n_done; e = n_err;
    rx = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    check("glitch_busy", rx_busy, 1);
    rx = 1'b1;
    repeat (6 * DIV) @(negedge clk);
    check("glitch_idle", rx_busy, 0);
    check("glitch_done", n_done - d, 0);
    check("glitch_ferr", n_err - e, 0);
    d = n_done; e = n_err;
    send(8'hA3, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("ferr_cnt", n_err - e, 1);
    check("ferr_done", n_done - d, 0);
    check("ferr_data", rx_data, 8'h55);
    d = n_done; qs = got_q.size();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    repeat (BIT) @(negedge clk);
    check("b2b_cnt", n_done - d, 2);
    check("b2b_first", got_q[qs], 8'h00);
    check("b2b_second", got_q[qs + 1], 8'hFF);
    check("b2b_data", rx_data, 8'hFF);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    d = n_done; e = n_err;
    rst = 1'b1;
    #1;
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_done", rx_done, 0);
    check("mid_rst_ferr", frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    check("mid_rst_nodone", n_done - d, 0);
    check("mid_rst_noferr", n_err - e, 0);
    d = n_done;
    send(8'h3C, 1'b1);
    repeat (BIT) @(negedge clk);
    check("f3c_cnt", n_done - d, 1);
    check("f3c_data", rx_data, 8'h3C);
    check("excl", n_both, 0);
    check("busy_at_done", n_busy_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
